paddle_ctrl: RTL and testbench
==============================

PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SLEW, default 16: max vpos change per frame in analog/paddle tracking.
REQ-002 Parameter STEP_MAX, default 8: max vpos change per frame in digital mode.
REQ-003 Parameter ACCEL_FRAMES, default 4: held frames per digital step increment.
REQ-004 Parameter DEADBAND, default 4: target drift that ends HOLD.
REQ-005 clk_sys  in  1  system clock (7.159 MHz); all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 vsync  in  1  video vertical sync, active-high level; its rising edge is the frame strobe.
REQ-008 mode  in  2  control source: 0=Y, 1=X, 2=Inv-X, 3=Paddle.
REQ-009 joy_up  in  1  digital up, active-high.
REQ-010 joy_down  in  1  digital down, active-high.
REQ-011 analog  in  16  stick, [15:8] Y and [7:0] X, each two's-complement signed.
REQ-012 paddle  in  8  unsigned paddle position.
REQ-013 vpos  out  8  paddle vertical position to game core, 0=top.
REQ-014 moving  out  1  high for the frame after any update that changed vpos.

Function
REQ-015 Target SHALL be combinational: mode0 analog[15:8]+0x80; mode1 analog[7:0]+0x80; mode2 analog[7:0]^0x7F; mode3 paddle; all 8-bit, wrap-free by construction.
REQ-016 Frame strobe SHALL be vsync=1 with registered vsync_d=0; all state updates occur only on strobe cycles; vpos/moving change on the clock edge ending the strobe cycle (1-cycle latency).
REQ-017 FSM states SHALL be TRACK, DIGITAL, HOLD.
REQ-018 TRACK: per strobe vpos moves toward target by min(|target-vpos|, SLEW); equal -> unchanged.
REQ-019 Any state, strobe with exactly one of joy_up/joy_down high -> DIGITAL (movement applied that same strobe).
REQ-020 DIGITAL: joy_up subtracts step, joy_down adds step; results SHALL saturate at 0x00 and 0xFF, never wrap.
REQ-021 step SHALL start at 1 on DIGITAL entry or direction reversal, increment by 1 after each ACCEL_FRAMES consecutive same-direction strobes, saturate at STEP_MAX.
REQ-022 Both joy_up and joy_down high on strobe: vpos unchanged, step reset to 1, state unchanged.
REQ-023 DIGITAL, strobe with neither pressed -> HOLD; latch current target as rel_target; vpos unchanged.
REQ-024 HOLD: vpos frozen; strobe with |target-rel_target| > DEADBAND or mode differing from mode latched at release -> TRACK (no movement that strobe).
REQ-025 Mode change while in TRACK SHALL slew, never jump.
REQ-026 Input changes between strobes SHALL have no effect; only values on the strobe cycle count.
REQ-027 vsync held high SHALL yield exactly one strobe.

Reset
REQ-028 On reset: vpos=0x80, moving=0, state=TRACK, step=1, hold counter=0, vsync_d=1 (no strobe on first cycle after reset if vsync high).
REQ-029 Reset mid-DIGITAL or mid-HOLD SHALL discard all state; first strobe after reset behaves as from TRACK.

Structure
REQ-030 Shared package pong_pkg SHALL hold the state enum, mode encodings, and default parameter constants.
REQ-031 Single module; instanced once per player in the top level; no sub-modules.

Verification
REQ-032 Reset, mode=3, paddle=0xFF, 8 strobes -> vpos 0x90,0xA0,...,0xF0,0xFF; moving high each, then low on 9th.
REQ-033 mode=0, analog[15:8]=0x00, vpos=0x80, joy_down held 10 strobes -> steps 1,1,1,1,2,2,2,2,3,3, vpos=0x92; release -> HOLD, vpos stays 0x92.
REQ-034 HOLD with rel_target=0x80: target 0x84 -> stays HOLD; target 0x85 -> TRACK next strobe, then slews toward 0x85.
REQ-035 vpos=0x02, joy_up held with step 3 -> vpos=0x00, no wrap; both buttons pressed -> vpos unchanged, step=1.
REQ-036 vsync held high 100 cycles -> one update; reset asserted in DIGITAL -> vpos=0x80, state TRACK next cycle.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared definitions for the paddle controllers: controller
//                state encoding, control-source (mode) encodings and the
//                default tuning constants used as parameter defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package pong_pkg;

    // Controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        TRACK   = 2'd0,
        DIGITAL = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Control-source selection.
    localparam logic [1:0] c_mode_y      = 2'd0;
    localparam logic [1:0] c_mode_x      = 2'd1;
    localparam logic [1:0] c_mode_inv_x  = 2'd2;
    localparam logic [1:0] c_mode_paddle = 2'd3;

    // Default tuning constants.
    localparam int c_slew_default         = 16;
    localparam int c_step_max_default     = 8;
    localparam int c_accel_frames_default = 4;
    localparam int c_deadband_default     = 4;

    // Reset / centre position of the paddle.
    localparam logic [7:0] c_vpos_centre = 8'h80;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_ctrl
//  Description : Per-player paddle position controller. Once per video frame
//                (rising edge of vsync) the vertical position either slews
//                toward an analog/paddle target (TRACK), steps with
//                accelerating digital buttons (DIGITAL), or stays frozen after
//                button release until the target drifts or the mode changes
//                (HOLD).
//  Ports       : clk_sys  in   system clock, rising edge
//                reset    in   synchronous active-high reset
//                vsync    in   vertical sync level; rising edge = frame strobe
//                mode     in   [1:0] 0=Y, 1=X, 2=inverted X, 3=paddle
//                joy_up   in   digital up button
//                joy_down in   digital down button
//                analog   in   [15:8] signed Y, [7:0] signed X
//                paddle   in   [7:0] unsigned paddle position
//                vpos     out  [7:0] paddle vertical position, 0 = top
//                moving   out  high for the frame after vpos changed
//  Revision    : 1.0  initial release
// ============================================================================
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SLEW         = c_slew_default,
    parameter int STEP_MAX     = c_step_max_default,
    parameter int ACCEL_FRAMES = c_accel_frames_default,
    parameter int DEADBAND     = c_deadband_default
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vsync,
    input  logic [1:0]  mode,
    input  logic        joy_up,
    input  logic        joy_down,
    input  logic [15:0] analog,
    input  logic [7:0]  paddle,
    output logic [7:0]  vpos,
    output logic        moving
);

    localparam logic [7:0] c_slew     = 8'(SLEW);
    localparam logic [7:0] c_step_max = 8'(STEP_MAX);
    localparam logic [7:0] c_accel    = 8'(ACCEL_FRAMES);
    localparam logic [7:0] c_deadband = 8'(DEADBAND);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_vsync_d;
    logic [7:0]  r_vpos;
    logic        r_moving;
    logic [7:0]  r_step;       // step applied on the next same-direction strobe
    logic [7:0]  r_cnt;        // strobes already applied at r_step
    logic        r_dir_down;   // direction of the last digital move
    logic [7:0]  r_rel_target; // target latched at button release
    logic [1:0]  r_rel_mode;   // mode latched at button release

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [7:0]  w_vpos_nxt;
    logic [7:0]  w_step_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_dir_down_nxt;
    logic [7:0]  w_rel_target_nxt;
    logic [1:0]  w_rel_mode_nxt;

    logic        w_strobe;
    logic [7:0]  w_target;
    logic        w_up_only;
    logic        w_dn_only;
    logic        w_both;
    logic        w_fresh;
    logic [7:0]  w_base_step;
    logic [7:0]  w_base_cnt;
    logic [8:0]  w_sum;
    logic [7:0]  w_diff;
    logic [7:0]  w_drift;

    assign w_strobe  = vsync & ~r_vsync_d;
    assign w_up_only = joy_up & ~joy_down;
    assign w_dn_only = joy_down & ~joy_up;
    assign w_both    = joy_up & joy_down;

    // Offsetting a signed byte by 0x80 maps -128..127 onto 0..255; the XOR
    // with 0x7F is the same offset combined with a full inversion.
    always_comb begin
        w_target = paddle;
        case (mode)
            c_mode_y:      w_target = analog[15:8] + 8'h80;
            c_mode_x:      w_target = analog[7:0] + 8'h80;
            c_mode_inv_x:  w_target = analog[7:0] ^ 8'h7F;
            default:       w_target = paddle;
        endcase
    end

    // A new run of steps starts on entry to DIGITAL or on reversal.
    assign w_fresh     = (r_state != DIGITAL) || (r_dir_down != w_dn_only);
    assign w_base_step = w_fresh ? 8'd1 : r_step;
    assign w_base_cnt  = w_fresh ? 8'd0 : r_cnt;
    assign w_sum       = {1'b0, r_vpos} + {1'b0, w_base_step};
    assign w_drift     = (w_target >= r_rel_target) ? (w_target - r_rel_target)
                                                    : (r_rel_target - w_target);

    always_comb begin
        w_state_nxt      = r_state;
        w_vpos_nxt       = r_vpos;
        w_step_nxt       = r_step;
        w_cnt_nxt        = r_cnt;
        w_dir_down_nxt   = r_dir_down;
        w_rel_target_nxt = r_rel_target;
        w_rel_mode_nxt   = r_rel_mode;
        w_diff           = 8'd0;

        if (w_up_only || w_dn_only) begin
            w_state_nxt    = DIGITAL;
            w_dir_down_nxt = w_dn_only;
            if (w_dn_only) begin
                w_vpos_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
            end else begin
                w_vpos_nxt = (r_vpos >= w_base_step) ? (r_vpos - w_base_step) : 8'h00;
            end
            // After ACCEL_FRAMES strobes at one step size, grow the step.
            if ((w_base_cnt + 8'd1) >= c_accel) begin
                w_cnt_nxt  = 8'd0;
                w_step_nxt = (w_base_step >= c_step_max) ? c_step_max : (w_base_step + 8'd1);
            end else begin
                w_cnt_nxt  = w_base_cnt + 8'd1;
                w_step_nxt = w_base_step;
            end
        end else if (w_both) begin
            w_step_nxt = 8'd1;
            w_cnt_nxt  = 8'd0;
        end else begin
            case (r_state)
                TRACK: begin
                    if (w_target > r_vpos) begin
                        w_diff     = w_target - r_vpos;
                        w_vpos_nxt = (w_diff > c_slew) ? (r_vpos + c_slew) : w_target;
                    end else if (w_target < r_vpos) begin
                        w_diff     = r_vpos - w_target;
                        w_vpos_nxt = (w_diff > c_slew) ? (r_vpos - c_slew) : w_target;
                    end
                end
                DIGITAL: begin
                    w_state_nxt      = HOLD;
                    w_rel_target_nxt = w_target;
                    w_rel_mode_nxt   = mode;
                end
                HOLD: begin
                    // Leaving HOLD does not move on the same strobe.
                    if ((w_drift > c_deadband) || (mode != r_rel_mode)) begin
                        w_state_nxt = TRACK;
                    end
                end
                default: begin
                    w_state_nxt = TRACK;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= TRACK;
            r_vsync_d    <= 1'b1;
            r_vpos       <= c_vpos_centre;
            r_moving     <= 1'b0;
            r_step       <= 8'd1;
            r_cnt        <= 8'd0;
            r_dir_down   <= 1'b0;
            r_rel_target <= 8'h00;
            r_rel_mode   <= c_mode_y;
        end else begin
            r_vsync_d <= vsync;
            if (w_strobe) begin
                r_state      <= w_state_nxt;
                r_vpos       <= w_vpos_nxt;
                r_moving     <= (w_vpos_nxt != r_vpos);
                r_step       <= w_step_nxt;
                r_cnt        <= w_cnt_nxt;
                r_dir_down   <= w_dir_down_nxt;
                r_rel_target <= w_rel_target_nxt;
                r_rel_mode   <= w_rel_mode_nxt;
            end
        end
    end

    assign vpos   = r_vpos;
    assign moving = r_moving;

endmodule : paddle_ctrl
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_ctrl
//  Description : Directed self-checking bench for paddle_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_paddle_ctrl;
    import pong_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        vsync   = 1'b0;
    logic [1:0]  mode    = 2'd3;
    logic        joy_up  = 1'b0;
    logic        joy_down = 1'b0;
    logic [15:0] analog  = 16'h0000;
    logic [7:0]  paddle  = 8'h80;
    logic [7:0]  vpos;
    logic        moving;

    int n_vec = 0;
    int n_err = 0;

    paddle_ctrl dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vsync    (vsync),
        .mode     (mode),
        .joy_up   (joy_up),
        .joy_down (joy_down),
        .analog   (analog),
        .paddle   (paddle),
        .vpos     (vpos),
        .moving   (moving)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One frame strobe; returns at the negedge after the updating edge.
    task automatic frame();
        @(negedge clk_sys) vsync = 1'b1;
        @(negedge clk_sys) vsync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys) reset = 1'b1;
        @(negedge clk_sys) reset = 1'b0;
    endtask

    logic [7:0] exp_up [0:8]  = '{8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h08, 8'h06, 8'h04, 8'h02, 8'h00};
    logic [7:0] exp_dn [0:9]  = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h88, 8'h8A, 8'h8C, 8'h8F, 8'h92};

    initial begin
        // Reset state
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        chk("reset_vpos", vpos, 8'h80);
        chk("reset_moving", {7'd0, moving}, 8'h00);
        chk("reset_state", {6'd0, dut.r_state}, {6'd0, TRACK});

        // Paddle tracking with slew limit
        mode = 2'd3; paddle = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            frame();
            chk($sformatf("slew_vpos_%0d", i), vpos, (i == 7) ? 8'hFF : 8'(8'h90 + 8'(i * 16)));
            chk($sformatf("slew_moving_%0d", i), {7'd0, moving}, 8'h01);
        end
        frame();
        chk("slew_settled_vpos", vpos, 8'hFF);
        chk("slew_settled_moving", {7'd0, moving}, 8'h00);

        // Digital acceleration
        do_reset();
        mode = 2'd0; analog = 16'h0000;
        joy_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame();
            chk($sformatf("accel_vpos_%0d", i), vpos, exp_dn[i]);
        end
        joy_down = 1'b0;
        frame();
        chk("release_vpos", vpos, 8'h92);
        chk("release_state", {6'd0, dut.r_state}, {6'd0, HOLD});
        chk("release_moving", {7'd0, moving}, 8'h00);

        // Deadband around the released target 0x80
        analog = 16'h0400;
        frame();
        chk("deadband_in_vpos", vpos, 8'h92);
        chk("deadband_in_state", {6'd0, dut.r_state}, {6'd0, HOLD});
        analog = 16'h0500;
        frame();
        chk("deadband_out_vpos", vpos, 8'h92);
        chk("deadband_out_state", {6'd0, dut.r_state}, {6'd0, TRACK});
        frame();
        chk("retrack_vpos", vpos, 8'h85);
        chk("retrack_moving", {7'd0, moving}, 8'h01);

        // Mode change in TRACK slews toward paddle 0x0E
        mode = 2'd3; paddle = 8'h0E;
        frame();
        chk("mode_change_slew", vpos, 8'h75);
        repeat (7) frame();
        chk("slew_down_done", vpos, 8'h0E);

        // Upward steps saturate at the top
        joy_up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            frame();
            chk($sformatf("up_vpos_%0d", i), vpos, exp_up[i]);
        end
        frame();
        chk("up_sat_vpos", vpos, 8'h00);
        chk("up_sat_step", dut.r_step, 8'h03);
        joy_down = 1'b1;
        frame();
        chk("both_vpos", vpos, 8'h00);
        chk("both_step", dut.r_step, 8'h01);
        chk("both_state", {6'd0, dut.r_state}, {6'd0, DIGITAL});

        // vsync held high yields a single update
        joy_up = 1'b0;
        @(negedge clk_sys) vsync = 1'b1;
        repeat (100) @(negedge clk_sys);
        vsync = 1'b0;
        chk("vsync_held_vpos", vpos, 8'h01);
        chk("vsync_held_moving", {7'd0, moving}, 8'h01);

        // Reset in DIGITAL discards state
        do_reset();
        chk("mid_reset_vpos", vpos, 8'h80);
        chk("mid_reset_state", {6'd0, dut.r_state}, {6'd0, TRACK});
        joy_down = 1'b0;
        frame();
        chk("post_reset_track", vpos, 8'h70);

        // Input changes between strobes are ignored
        @(negedge clk_sys) paddle = 8'hFF;
        @(negedge clk_sys) paddle = 8'h0E;
        frame();
        chk("between_strobes", vpos, 8'h60);

        // Inverted X and X source selection
        mode = 2'd2; analog = 16'h007F;
        frame();
        chk("inv_x_slew", vpos, 8'h50);
        mode = 2'd1;
        frame();
        chk("x_slew", vpos, 8'h60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_paddle_ctrl
`default_nettype wire
